// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between N_REQ byte clients.
// An idle watchdog revokes and blocks a stalled owner until it drops req.
module uart_tx_arbiter #(
    parameter int N_REQ      = 3,
    parameter int IDW        = 2,
    parameter int IDLE_LIMIT = 1000000,
    parameter int WD_W       = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   cli_tx_start,
    input  logic [8*N_REQ-1:0] cli_tx_data,
    output logic [N_REQ-1:0]   cli_tx_busy,
    output logic [N_REQ-1:0]   gnt,
    output logic [IDW-1:0]     owner_id,
    output logic               uart_tx_start,
    output logic [7:0]         uart_tx_data,
    input  logic               uart_tx_busy,
    output logic               timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned NR = N_REQ;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   owner_id_q, owner_id_d;
    logic [IDW-1:0]   last_owner_q, last_owner_d;
    logic [N_REQ-1:0] blocked_q, blocked_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic             own_req;
    logic             own_start;
    logic [7:0]       own_data;
    logic [N_REQ-1:0] own_onehot;
    logic             release_w;
    logic             wd_idle;
    logic             expire;
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [IDW-1:0]   pick;
    logic [N_REQ-1:0] pick_onehot;

    function automatic int unsigned rr_wrap(input int unsigned v);
        return (v >= NR) ? v - NR : v;
    endfunction

    always_comb begin
        own_req    = 1'b0;
        own_start  = 1'b0;
        own_data   = '0;
        own_onehot = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (owner_id_q == IDW'(i)) begin
                own_req       = req[i];
                own_start     = cli_tx_start[i];
                own_data      = cli_tx_data[8*i +: 8];
                own_onehot[i] = 1'b1;
            end
        end
    end

    // A release on the expiry cycle wins: normal hand-over, no timeout, no block.
    assign release_w = (state_q == ST_OWN) && !own_req;
    assign wd_idle   = !own_start && !uart_tx_busy;
    assign expire    = (IDLE_LIMIT != 0) && (state_q == ST_OWN) && !release_w
                       && (wd_q == WD_W'(IDLE_LIMIT));
    assign eligible  = req & ~blocked_q;

    // Round-robin search begins at the client after the most recent owner.
    always_comb begin
        found       = 1'b0;
        pick        = '0;
        pick_onehot = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            for (int unsigned j = 0; j < NR; j++) begin
                if (!found && eligible[j] && (j == rr_wrap(32'(last_owner_q) + k))) begin
                    found          = 1'b1;
                    pick           = IDW'(j);
                    pick_onehot[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_id_d   = owner_id_q;
        last_owner_d = last_owner_q;
        blocked_d    = blocked_q & req;
        wd_d         = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d        = pick_onehot;
                    owner_id_d   = pick;
                    last_owner_d = pick;
                    state_d      = ST_OWN;
                end
            end
            ST_OWN: begin
                if (release_w || expire) begin
                    gnt_d   = '0;
                    state_d = uart_tx_busy ? ST_DRAIN : ST_IDLE;
                    if (expire) begin
                        blocked_d = blocked_d | own_onehot;
                    end
                end else if ((IDLE_LIMIT != 0) && wd_idle) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                gnt_d = '0;
                if (!uart_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_id_q   <= '0;
            last_owner_q <= IDW'(N_REQ - 1);
            blocked_q    <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_id_q   <= owner_id_d;
            last_owner_q <= last_owner_d;
            blocked_q    <= blocked_d;
            wd_q         <= wd_d;
        end
    end

    assign uart_tx_start = (state_q == ST_OWN) && own_start && own_req;
    assign uart_tx_data  = (state_q == ST_OWN) ? own_data : '0;
    assign cli_tx_busy   = ((state_q == ST_OWN) && uart_tx_busy) ? own_onehot : '0;
    assign gnt           = gnt_q;
    assign owner_id      = owner_id_q;
    assign timeout       = expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle check against a message-level ownership model,
// with a behavioural UART busy generator and directed client message scenarios.
module tb_uart_tx_arbiter;

    localparam int NC       = 3;
    localparam int LIM      = 16;
    localparam int BYTE_CYC = 4;
    localparam int WAIT_MAX = 400;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       r [NC];
    logic       s [NC];
    logic [7:0] d [NC];
    logic [2:0] req, cst;
    logic [23:0] cdat;
    logic [2:0] cli_busy, gnt;
    logic [1:0] owner_id;
    logic       utx_start;
    logic [7:0] utx_data;
    logic       ubusy = 1'b0;
    logic       tmo;

    int total = 0;
    int bad   = 0;
    logic [7:0] ulog [$];
    int         gq [$];
    int         to_m;
    int         dly;

    assign req  = {r[2], r[1], r[0]};
    assign cst  = {s[2], s[1], s[0]};
    assign cdat = {d[2], d[1], d[0]};

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(3), .IDW(2), .IDLE_LIMIT(LIM), .WD_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cli_tx_start(cst), .cli_tx_data(cdat),
        .cli_tx_busy(cli_busy), .gnt(gnt), .owner_id(owner_id), .uart_tx_start(utx_start),
        .uart_tx_data(utx_data), .uart_tx_busy(ubusy), .timeout(tmo)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // UART: latch a byte when start is seen while idle, then stay busy BYTE_CYC cycles.
    int         ucnt = 0;
    logic       ust;
    logic [7:0] udt;
    always begin
        @(negedge clk);
        ust = utx_start;
        udt = utx_data;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ucnt  = 0;
            ubusy = 1'b0;
        end else if (ucnt > 0) begin
            ucnt--;
            ubusy = (ucnt > 0);
        end else if (ust) begin
            ulog.push_back(udt);
            ucnt  = BYTE_CYC;
            ubusy = 1'b1;
        end
    end

    // Ownership model: who holds the UART, whether it is still draining, idle count.
    int         m_own  = -1;
    logic       m_drain = 1'b0;
    int         m_last = NC - 1;
    int         m_id   = 0;
    logic [NC-1:0] m_blk = '0;
    int         m_idle = 0;
    logic [2:0] m_pgnt = '0;
    always @(negedge clk) begin
        logic [2:0] e_gnt, e_cb;
        logic       e_st, e_to, fnd;
        logic [7:0] e_dat;
        int         c;
        if (!rst_n) begin
            m_own = -1; m_drain = 1'b0; m_last = NC - 1; m_id = 0; m_blk = '0; m_idle = 0;
        end
        e_gnt = '0; e_cb = '0; e_st = 1'b0; e_to = 1'b0; e_dat = '0;
        if (m_own >= 0) begin
            e_gnt[m_own] = 1'b1;
            e_cb[m_own]  = ubusy;
            e_st         = s[m_own] & r[m_own];
            e_dat        = d[m_own];
            e_to         = r[m_own] && (m_idle == LIM);
        end
        chk("m_gnt", 32'(gnt), 32'(e_gnt));
        chk("m_owner_id", 32'(owner_id), 32'(m_id));
        chk("m_uart_start", 32'(utx_start), 32'(e_st));
        chk("m_uart_data", 32'(utx_data), 32'(e_dat));
        chk("m_cli_busy", 32'(cli_busy), 32'(e_cb));
        chk("m_timeout", 32'(tmo), 32'(e_to));
        if (rst_n && gnt != 0 && m_pgnt == 0) gq.push_back(int'(owner_id));
        m_pgnt = rst_n ? gnt : '0;
        if (rst_n) begin
            if (m_own >= 0) begin
                if (!r[m_own]) begin
                    m_drain = ubusy; m_own = -1; m_idle = 0;
                end else if (m_idle == LIM) begin
                    m_blk[m_own] = 1'b1; m_drain = ubusy; m_own = -1; m_idle = 0;
                end else if (s[m_own] || ubusy) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end else if (m_drain) begin
                if (!ubusy) m_drain = 1'b0;
            end else begin
                fnd = 1'b0;
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last + k) % NC;
                    if (!fnd && r[c] && !m_blk[c]) begin
                        fnd = 1'b1; m_own = c; m_last = c; m_id = c;
                    end
                end
            end
            for (int i = 0; i < NC; i++) if (!r[i]) m_blk[i] = 1'b0;
        end
    end

    task automatic wait_cbusy(input int c, input logic lvl, input string nm);
        int to = 0;
        @(negedge clk);
        while (cli_busy[c] !== lvl && to < WAIT_MAX) begin
            @(negedge clk);
            to++;
        end
        chk(nm, 32'(to < WAIT_MAX), 1);
    endtask

    task automatic send(input int c, input int n, input logic [7:0] base);
        @(posedge clk); #1;
        r[c] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            d[c] = base + 8'(k);
            s[c] = 1'b1;
            wait_cbusy(c, 1'b1, "busy_rise");
            @(posedge clk); #1;
            s[c] = 1'b0;
            wait_cbusy(c, 1'b0, "busy_fall");
        end
        @(posedge clk); #1;
        r[c] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < NC; i++) begin
            r[i] = 1'b0; s[i] = 1'b0; d[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ulog.delete();
        gq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench exceeded time limit");
    end

    initial begin
        logic [7:0] exp2 [6];
        logic [7:0] exp3 [6];
        exp2 = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
        exp3 = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h62};
        for (int i = 0; i < NC; i++) begin
            r[i] = 1'b0; s[i] = 1'b0; d[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_owner_id", 32'(owner_id), 0);
        chk("rst_uart_start", 32'(utx_start), 0);
        chk("rst_uart_data", 32'(utx_data), 0);
        chk("rst_cli_busy", 32'(cli_busy), 0);
        chk("rst_timeout", 32'(tmo), 0);
        rst_n = 1'b1;

        // single client 1 sends 0x41
        fork
            send(1, 1, 8'h41);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("t1_gnt_before", 32'(gnt), 0);
                @(negedge clk);
                chk("t1_gnt", 32'(gnt), 'b010);
            end
        join
        @(negedge clk);
        chk("t1_gnt_hold", 32'(gnt), 'b010);
        @(negedge clk);
        chk("t1_gnt_released", 32'(gnt), 0);
        chk("t1_nbytes", 32'(ulog.size()), 1);
        chk("t1_byte", (ulog.size() > 0) ? 32'(ulog[0]) : 32'hFFFF_FFFF, 'h41);

        // contention: clients 0 and 2 together, three bytes each
        do_reset();
        fork
            send(0, 3, 8'h10);
            send(2, 3, 8'h30);
        join
        repeat (2) @(negedge clk);
        chk("t2_nbytes", 32'(ulog.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("t2_byte", (ulog.size() > i) ? 32'(ulog[i]) : 32'hFFFF_FFFF, 32'(exp2[i]));
        chk("t2_ngrants", 32'(gq.size()), 2);
        chk("t2_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF_FFFF, 0);
        chk("t2_second", (gq.size() > 1) ? 32'(gq[1]) : 32'hFFFF_FFFF, 2);

        // round robin: all three clients, two messages each
        do_reset();
        fork
            begin send(0, 1, 8'h50); send(0, 1, 8'h60); end
            begin send(1, 1, 8'h51); send(1, 1, 8'h61); end
            begin send(2, 1, 8'h52); send(2, 1, 8'h62); end
        join
        repeat (2) @(negedge clk);
        chk("t3_ngrants", 32'(gq.size()), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t3_order", (gq.size() > i) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(i % 3));
            chk("t3_byte", (ulog.size() > i) ? 32'(ulog[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));
        end

        // drain: owner releases while the UART is still busy
        do_reset();
        @(posedge clk); #1;
        r[0] = 1'b1; d[0] = 8'h55; s[0] = 1'b1;
        wait_cbusy(0, 1'b1, "t4_rise");
        @(posedge clk); #1;
        s[0] = 1'b0; r[0] = 1'b0;
        fork
            send(1, 1, 8'h66);
            begin
                @(negedge clk);
                chk("t4_own_gnt", 32'(gnt), 'b001);
                chk("t4_own_busy", 32'(cli_busy), 'b001);
                @(negedge clk);
                chk("t4_drain_gnt", 32'(gnt), 0);
                chk("t4_drain_start", 32'(utx_start), 0);
                chk("t4_drain_busy", 32'(cli_busy), 0);
                to_m = 0;
                while (ubusy && to_m < WAIT_MAX) begin
                    @(negedge clk);
                    to_m++;
                end
                chk("t4_busy_fall", 32'(to_m < WAIT_MAX), 1);
                chk("t4_m_gnt", 32'(gnt), 0);
                @(negedge clk);
                chk("t4_m1_gnt", 32'(gnt), 0);
                @(negedge clk);
                chk("t4_m2_gnt", 32'(gnt), 'b010);
            end
        join
        repeat (3) @(negedge clk);

        // watchdog: client 0 holds req but never starts a byte
        do_reset();
        @(posedge clk); #1;
        r[0] = 1'b1;
        fork
            send(1, 1, 8'h77);
            begin
                to_m = 0;
                @(negedge clk);
                while (gnt !== 3'b001 && to_m < WAIT_MAX) begin
                    @(negedge clk);
                    to_m++;
                end
                chk("t5_grant0", 32'(gnt), 'b001);
                dly = 0;
                while (!tmo && dly < 100) begin
                    @(negedge clk);
                    dly++;
                end
                chk("t5_wd_delay", 32'(dly), 16);
                @(negedge clk);
                chk("t5_pulse_end", 32'(tmo), 0);
                chk("t5_gap_gnt", 32'(gnt), 0);
                @(negedge clk);
                chk("t5_next_gnt", 32'(gnt), 'b010);
            end
        join
        repeat (2) @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("t5_blocked", 32'(gnt), 0);
        end
        @(posedge clk); #1;
        r[0] = 1'b0;
        @(posedge clk); #1;
        r[0] = 1'b1;
        @(negedge clk);
        chk("t5_rereq_wait", 32'(gnt), 0);
        @(negedge clk);
        chk("t5_regrant", 32'(gnt), 'b001);
        @(posedge clk); #1;
        r[0] = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of a byte
        do_reset();
        @(posedge clk); #1;
        r[1] = 1'b1; d[1] = 8'hA5; s[1] = 1'b1;
        wait_cbusy(1, 1'b1, "t6_rise");
        chk("t6_pre_gnt", 32'(gnt), 'b010);
        chk("t6_pre_data", 32'(utx_data), 'hA5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        r[1] = 1'b0; s[1] = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_owner_id", 32'(owner_id), 0);
        chk("t6_rst_start", 32'(utx_start), 0);
        chk("t6_rst_data", 32'(utx_data), 0);
        chk("t6_rst_busy", 32'(cli_busy), 0);
        chk("t6_rst_timeout", 32'(tmo), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r[0] = 1'b1; r[1] = 1'b1; r[2] = 1'b1;
        @(negedge clk);
        chk("t6_arb_wait", 32'(gnt), 0);
        @(negedge clk);
        chk("t6_first_gnt", 32'(gnt), 'b001);
        chk("t6_first_id", 32'(owner_id), 0);
        @(posedge clk); #1;
        r[0] = 1'b0; r[1] = 1'b0; r[2] = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
